// File: rtl/rca_dispatch_ctrl.sv
// rca_dispatch_ctrl: in-order RCA dispatch FIFO with per-RCA IDLE/RUN/RESULT FSMs and round-robin writeback
module rca_dispatch_ctrl #(
  parameter int NUM_RCAS = 3,
  parameter int ID_W = 3,
  parameter int DEPTH = 4,
  parameter int SEL_W = $clog2(NUM_RCAS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  output logic                issue_ready,
  input  logic [SEL_W-1:0]    issue_rca_sel,
  input  logic [ID_W-1:0]     issue_id,
  output logic [NUM_RCAS-1:0] rca_start,
  output logic [ID_W-1:0]     rca_start_id,
  input  logic [NUM_RCAS-1:0] rca_done,
  output logic                wb_done,
  output logic [ID_W-1:0]     wb_id,
  output logic [NUM_RCAS-1:0] rca_busy,
  output logic                sel_err
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, RESULT} state_t;
  state_t state [NUM_RCAS];
  state_t state_nx [NUM_RCAS];
  logic [ID_W-1:0] ids [NUM_RCAS];
  logic [SEL_W+ID_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [SEL_W-1:0] head_sel, rr_ptr, gnt;
  logic [ID_W-1:0] head_id;
  logic [2**SEL_W-1:0] idle;
  logic push, pop, bad, gnt_any;
  assign {head_sel, head_id} = mem[rd_ptr];
  assign issue_ready = count != (AW+1)'(DEPTH);
  assign push = issue_valid && issue_ready;
  assign bad = int'(head_sel) >= NUM_RCAS;
  // idle is padded to the full select range so out-of-range heads index safely
  assign pop = count != '0 && (bad || idle[head_sel]);
  assign rca_start = (pop && !bad) ? NUM_RCAS'(1) << head_sel : '0;
  assign rca_start_id = (pop && !bad) ? head_id : '0;
  always_comb begin
    idle = '0;
    rca_busy = '0;
    for (int i = 0; i < NUM_RCAS; i++) begin
      idle[i] = state[i] == IDLE;
      rca_busy[i] = state[i] != IDLE;
    end
  end
  always_comb begin
    gnt_any = 1'b0;
    gnt = '0;
    for (int k = 0; k < NUM_RCAS; k++)
      if (!gnt_any && state[(int'(rr_ptr) + k) % NUM_RCAS] == RESULT) begin
        gnt_any = 1'b1;
        gnt = SEL_W'((int'(rr_ptr) + k) % NUM_RCAS);
      end
  end
  always_comb begin
    for (int i = 0; i < NUM_RCAS; i++)
      state_nx[i] = (state[i] == IDLE && rca_start[i]) ? RUN :
                    (state[i] == RUN && rca_done[i]) ? RESULT :
                    (state[i] == RESULT && gnt_any && int'(gnt) == i) ? IDLE : state[i];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      rr_ptr <= '0;
      wb_done <= 1'b0;
      wb_id <= '0;
      sel_err <= 1'b0;
      for (int i = 0; i < NUM_RCAS; i++) begin
        state[i] <= IDLE;
        ids[i] <= '0;
      end
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (pop && bad) sel_err <= 1'b1;
      wb_done <= gnt_any;
      if (gnt_any) begin
        wb_id <= ids[gnt];
        rr_ptr <= (int'(gnt) == NUM_RCAS - 1) ? '0 : gnt + 1'b1;
      end
      for (int i = 0; i < NUM_RCAS; i++) begin
        state[i] <= state_nx[i];
        if (rca_start[i]) ids[i] <= head_id;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {issue_rca_sel, issue_id};
  end
endmodule

// File: tb/tb_rca_dispatch_ctrl.sv
// tb_rca_dispatch_ctrl: vector table, corner sequences and randomized run against a queue-based model
module tb_rca_dispatch_ctrl;
  localparam int N = 3, ID_W = 3, DEPTH = 4, SEL_W = 2;
  logic clk = 1'b0, rst = 1'b0, issue_valid = 1'b0, issue_ready;
  logic [SEL_W-1:0] issue_rca_sel = '0;
  logic [ID_W-1:0] issue_id = '0, rca_start_id, wb_id;
  logic [N-1:0] rca_start, rca_done = '0, rca_busy;
  logic wb_done, sel_err;
  always #5 clk = ~clk;
  rca_dispatch_ctrl #(.NUM_RCAS(N), .ID_W(ID_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rca_sel(issue_rca_sel), .issue_id(issue_id), .rca_start(rca_start),
    .rca_start_id(rca_start_id), .rca_done(rca_done), .wb_done(wb_done), .wb_id(wb_id),
    .rca_busy(rca_busy), .sel_err(sel_err)
  );
  typedef struct {int sel; int id;} ent_t;
  typedef struct {int cyc; int id;} ev_t;
  typedef struct {bit r; bit v; int sel; int id; int dn; bit rdy; int st; int st_id; int busy; bit wb; int wbid; bit err;} vec_t;
  int n_cmp = 0, n_err = 0, cyc = 0, obs_ready, obs_busy;
  ent_t q[$];
  ev_t st_log[$], wb_log[$];
  bit run[N], pend[N];
  int rid[N], rr, m_wbid;
  bit err, m_wb;
  vec_t tbl[16];
  task automatic chk(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask
  function automatic int find(input ev_t lg[$], input int id);
    foreach (lg[k]) if (lg[k].id == id) return lg[k].cyc;
    return -1;
  endfunction
  function automatic void model_reset();
    q.delete();
    for (int i = 0; i < N; i++) begin
      run[i] = 0;
      pend[i] = 0;
      rid[i] = 0;
    end
    rr = 0;
    err = 0;
    m_wb = 0;
    m_wbid = 0;
  endfunction
  task automatic check_model();
    int es, eid, eb;
    es = 0;
    eid = 0;
    eb = 0;
    if (q.size() > 0 && q[0].sel < N && !run[q[0].sel] && !pend[q[0].sel]) begin
      es = 1 << q[0].sel;
      eid = q[0].id;
    end
    for (int i = 0; i < N; i++) if (run[i] || pend[i]) eb |= 1 << i;
    chk("issue_ready", int'(issue_ready), int'(q.size() < DEPTH));
    chk("rca_start", int'(rca_start), es);
    if (es != 0) chk("rca_start_id", int'(rca_start_id), eid);
    chk("rca_busy", int'(rca_busy), eb);
    chk("wb_done", int'(wb_done), int'(m_wb));
    if (m_wb) chk("wb_id", int'(wb_id), m_wbid);
    chk("sel_err", int'(sel_err), int'(err));
    obs_ready = int'(issue_ready);
    obs_busy = int'(rca_busy);
    if (rca_start != '0) st_log.push_back(ev_t'{cyc, int'(rca_start_id)});
    if (wb_done) wb_log.push_back(ev_t'{cyc, int'(wb_id)});
  endtask
  function automatic void model_step(input bit v, input int s, input int id, input int dn, input bit r);
    int g, hs, sz;
    bit pop;
    if (r) begin
      model_reset();
      return;
    end
    g = -1;
    hs = -1;
    pop = 0;
    sz = q.size();
    for (int k = 0; k < N; k++) if (g < 0 && pend[(rr + k) % N]) g = (rr + k) % N;
    if (sz > 0) begin
      hs = q[0].sel;
      pop = hs >= N || (!run[hs] && !pend[hs]);
    end
    m_wb = g >= 0;
    if (g >= 0) begin
      m_wbid = rid[g];
      pend[g] = 0;
      rr = (g + 1) % N;
    end
    for (int i = 0; i < N; i++) if (run[i] && dn[i]) begin
      run[i] = 0;
      pend[i] = 1;
    end
    if (pop) begin
      if (hs >= N) err = 1;
      else begin
        run[hs] = 1;
        rid[hs] = q[0].id;
      end
      void'(q.pop_front());
    end
    if (v && sz < DEPTH) q.push_back(ent_t'{s, id});
  endfunction
  task automatic cycle(input bit v, input int s, input int id, input int dn, input bit r);
    @(negedge clk);
    check_model();
    issue_valid = v;
    issue_rca_sel = SEL_W'(s);
    issue_id = ID_W'(id);
    rca_done = N'(dn);
    rst = r;
    model_step(v, s, id, dn, r);
    @(posedge clk);
    cyc++;
  endtask
  task automatic hard_reset();
    @(negedge clk);
    rst = 1'b1;
    issue_valid = 1'b0;
    rca_done = '0;
    @(posedge clk);
    cyc++;
    model_reset();
    st_log.delete();
    wb_log.delete();
  endtask
  initial begin
    int c1, c2, c3, got, s, dn;
    tbl[0]  = '{0, 1, 1, 5, 0, 1, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 0, 0, 1, 2, 5, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 1, 0, 0, 2, 0, 0, 0};
    tbl[3]  = '{0, 0, 0, 0, 0, 1, 0, 0, 2, 0, 0, 0};
    tbl[4]  = '{0, 0, 0, 0, 2, 1, 0, 0, 2, 0, 0, 0};
    tbl[5]  = '{0, 0, 0, 0, 0, 1, 0, 0, 2, 0, 0, 0};
    tbl[6]  = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 5, 0};
    tbl[7]  = '{0, 1, 3, 7, 0, 1, 0, 0, 0, 0, 0, 0};
    tbl[8]  = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    tbl[9]  = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
    tbl[10] = '{0, 1, 1, 2, 0, 1, 0, 0, 0, 0, 0, 1};
    tbl[11] = '{0, 0, 0, 0, 0, 1, 2, 2, 0, 0, 0, 1};
    tbl[12] = '{1, 0, 0, 0, 0, 1, 0, 0, 2, 0, 0, 1};
    tbl[13] = '{0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0};
    tbl[14] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    tbl[15] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    hard_reset();
    @(negedge clk);
    chk("rst issue_ready", int'(issue_ready), 1);
    chk("rst rca_start", int'(rca_start), 0);
    chk("rst rca_start_id", int'(rca_start_id), 0);
    chk("rst wb_done", int'(wb_done), 0);
    chk("rst wb_id", int'(wb_id), 0);
    chk("rst rca_busy", int'(rca_busy), 0);
    chk("rst sel_err", int'(sel_err), 0);
    foreach (tbl[t]) begin
      @(negedge clk);
      chk($sformatf("t%0d issue_ready", t), int'(issue_ready), int'(tbl[t].rdy));
      chk($sformatf("t%0d rca_start", t), int'(rca_start), tbl[t].st);
      if (tbl[t].st != 0) chk($sformatf("t%0d rca_start_id", t), int'(rca_start_id), tbl[t].st_id);
      chk($sformatf("t%0d rca_busy", t), int'(rca_busy), tbl[t].busy);
      chk($sformatf("t%0d wb_done", t), int'(wb_done), int'(tbl[t].wb));
      if (tbl[t].wb) chk($sformatf("t%0d wb_id", t), int'(wb_id), tbl[t].wbid);
      chk($sformatf("t%0d sel_err", t), int'(sel_err), int'(tbl[t].err));
      rst = tbl[t].r;
      issue_valid = tbl[t].v;
      issue_rca_sel = SEL_W'(tbl[t].sel);
      issue_id = ID_W'(tbl[t].id);
      rca_done = N'(tbl[t].dn);
      @(posedge clk);
      cyc++;
    end
    hard_reset();
    cycle(1, 0, 1, 0, 0);
    cycle(1, 0, 2, 0, 0);
    cycle(1, 2, 3, 0, 0);
    repeat (4) cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);
    repeat (6) cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 5, 0);
    repeat (6) cycle(0, 0, 0, 0, 0);
    c1 = find(wb_log, 1);
    c2 = find(st_log, 2);
    c3 = find(st_log, 3);
    chk("hol id2 started after id1 writeback", int'(c1 >= 0 && c2 >= c1), 1);
    chk("hol id3 started after id2", int'(c2 >= 0 && c3 > c2), 1);
    chk("hol id3 written back", int'(find(wb_log, 3) >= 0), 1);
    hard_reset();
    for (int i = 0; i < 5; i++) cycle(1, 0, i, 0, 0);
    cycle(1, 0, 6, 0, 0);
    chk("full issue_ready low", obs_ready, 0);
    repeat (2) cycle(1, 0, 6, 0, 0);
    chk("full issue_ready held low", obs_ready, 0);
    cycle(1, 0, 6, 1, 0);
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      cycle(1, 0, 6, 0, 0);
      got = obs_ready;
    end
    chk("full issue_ready returns", got, 1);
    repeat (30) cycle(0, 0, 0, 1, 0);
    chk("full id6 written back", int'(find(wb_log, 6) >= 0), 1);
    hard_reset();
    cycle(1, 0, 1, 0, 0);
    cycle(1, 1, 2, 0, 0);
    cycle(1, 2, 3, 0, 0);
    repeat (3) cycle(0, 0, 0, 0, 0);
    chk("rr all busy", obs_busy, 7);
    wb_log.delete();
    cycle(0, 0, 0, 7, 0);
    repeat (5) cycle(0, 0, 0, 0, 0);
    chk("rr count", wb_log.size(), 3);
    if (wb_log.size() == 3) begin
      chk("rr first", wb_log[0].id, 1);
      chk("rr second", wb_log[1].id, 2);
      chk("rr third", wb_log[2].id, 3);
      chk("rr consecutive", wb_log[2].cyc - wb_log[0].cyc, 2);
    end
    cycle(1, 2, 6, 0, 0);
    cycle(1, 0, 4, 0, 0);
    cycle(1, 1, 5, 0, 0);
    repeat (4) cycle(0, 0, 0, 0, 0);
    wb_log.delete();
    cycle(0, 0, 0, 7, 0);
    repeat (5) cycle(0, 0, 0, 0, 0);
    chk("rr2 count", wb_log.size(), 3);
    if (wb_log.size() == 3) begin
      chk("rr2 first", wb_log[0].id, 4);
      chk("rr2 second", wb_log[1].id, 5);
      chk("rr2 third", wb_log[2].id, 6);
    end
    hard_reset();
    for (int i = 0; i < 3000; i++) begin
      s = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
      dn = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : 0;
      cycle(bit'($urandom_range(0, 1)), s, int'($urandom_range(0, 7)), dn, $urandom_range(0, 499) == 0);
    end
    @(negedge clk);
    check_model();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
